// File: rtl/vc_input_fifo.sv
// Per-virtual-channel input buffer ahead of the referee: DEPTH-entry FIFO, 1-cycle registered read.
// Backpressure upstream via full/almost_full; a push while full is accepted only with a same-cycle pop.
module vc_input_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign empty        = (count == '0);
  assign almost_empty = (count <= AE_C);

  // A pop frees the head slot this cycle, so a push into a full FIFO is legal alongside it.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // When full with push+pop, wr_ptr == rd_ptr: the read below sees the old word.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        data_out  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
      count <= count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
      if ((push & full & ~pop) | (pop & empty)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_input_fifo.sv
// Directed bench for vc_input_fifo: reset, fill/drain, overflow, underflow, full push+pop wrap, thresholds.
module tb_vc_input_fifo;

  logic        clk;
  logic        reset;
  logic        push;
  logic [11:0] data_in;
  logic        pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        almost_empty;
  logic [3:0]  count;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  vc_input_fifo #(.DATA_WIDTH(12), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty), .count(count), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request set, let one edge consume it, return 1 time unit after the edge.
  task automatic step(input logic p, input logic [11:0] d, input logic q);
    push = p; data_in = d; pop = q;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    // flags {empty, almost_empty, full, almost_full, valid_out, error}
    #3;
    n_checks++;
    if ({empty, almost_empty, full, almost_full, valid_out, error} !== 6'b110000) begin
      n_fail++; $display("FAIL reset_init_flags: got %b want 110000", {empty, almost_empty, full, almost_full, valid_out, error});
    end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL reset_init_count: got %0d want 0", count); end
    reset = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 12'h000, 1'b1);
    step(1'b1, 12'h321, 1'b0);
    step(1'b1, 12'h322, 1'b1);
    n_checks++;
    if (count !== 4'd1 || error !== 1'b1 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_state: count=%0d error=%b valid=%b want 1 1 1", count, error, valid_out);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({empty, almost_empty, full, almost_full, valid_out, error} !== 6'b110000 || count !== 4'd0 || data_out !== 12'h000) begin
      n_fail++; $display("FAIL reset_async: flags=%b count=%0d data=%h want 110000 0 000",
                         {empty, almost_empty, full, almost_full, valid_out, error}, count, data_out);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 12'(i + 1), 1'b0);
      n_checks++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || full !== (i + 1 == 8) || empty !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b want %0d %b %b 0",
                           i, count, almost_full, full, empty, i + 1, (i + 1 >= 6), (i + 1 == 8));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 12'h000, 1'b1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 12'(i + 1) || count !== 4'(7 - i)) begin
        n_fail++; $display("FAIL drain_%0d: valid=%b data=%h count=%0d want 1 %h %0d", i, valid_out, data_out, count, 12'(i + 1), 7 - i);
      end
    end
    step(1'b0, 12'h000, 1'b0);
    n_checks++;
    if (valid_out !== 1'b0 || empty !== 1'b1 || data_out !== 12'h008 || error !== 1'b0) begin
      n_fail++; $display("FAIL drain_end: valid=%b empty=%b data=%h error=%b want 0 1 008 0", valid_out, empty, data_out, error);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 12'h100 + 12'(i), 1'b0);
    step(1'b1, 12'hABC, 1'b0);
    n_checks++;
    if (count !== 4'd8 || full !== 1'b1 || error !== 1'b1) begin
      n_fail++; $display("FAIL overflow: count=%0d full=%b error=%b want 8 1 1", count, full, error);
    end
    step(1'b0, 12'h000, 1'b0);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: error=%b want 1", error); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 12'h000, 1'b1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 12'h100 + 12'(i)) begin
        n_fail++; $display("FAIL overflow_drain_%0d: valid=%b data=%h want 1 %h", i, valid_out, data_out, 12'h100 + 12'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || error !== 1'b1) begin n_fail++; $display("FAIL overflow_end: empty=%b error=%b want 1 1", empty, error); end
  endtask

  task automatic test_underflow();
    pulse_reset();
    step(1'b0, 12'h000, 1'b1);
    n_checks++;
    if (valid_out !== 1'b0 || count !== 4'd0 || error !== 1'b1) begin
      n_fail++; $display("FAIL underflow: valid=%b count=%0d error=%b want 0 0 1", valid_out, count, error);
    end
    step(1'b1, 12'h055, 1'b1);
    n_checks++;
    if (count !== 4'd1 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL underflow_pushpop: count=%0d valid=%b want 1 0", count, valid_out);
    end
    step(1'b0, 12'h000, 1'b1);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 12'h055 || count !== 4'd0) begin
      n_fail++; $display("FAIL underflow_read: valid=%b data=%h count=%0d want 1 055 0", valid_out, data_out, count);
    end
  endtask

  task automatic test_full_wrap();
    pulse_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 12'h010 + 12'(i), 1'b0);
    step(1'b1, 12'h018, 1'b1);
    n_checks++;
    if (data_out !== 12'h010 || valid_out !== 1'b1 || full !== 1'b1 || count !== 4'd8 || error !== 1'b0) begin
      n_fail++; $display("FAIL full_pushpop: data=%h valid=%b full=%b count=%0d error=%b want 010 1 1 8 0",
                         data_out, valid_out, full, count, error);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 12'h000, 1'b1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 12'h011 + 12'(i)) begin
        n_fail++; $display("FAIL wrap_drain_%0d: valid=%b data=%h want 1 %h", i, valid_out, data_out, 12'h011 + 12'(i));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL wrap_end: empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_thresholds();
    step(1'b1, 12'h201, 1'b0);
    n_checks++;
    if (almost_empty !== 1'b1 || count !== 4'd1) begin n_fail++; $display("FAIL ae_at_1: ae=%b count=%0d want 1 1", almost_empty, count); end
    step(1'b1, 12'h202, 1'b0);
    n_checks++;
    if (almost_empty !== 1'b0 || count !== 4'd2) begin n_fail++; $display("FAIL ae_at_2: ae=%b count=%0d want 0 2", almost_empty, count); end
    for (int i = 3; i <= 5; i++) step(1'b1, 12'h200 + 12'(i), 1'b0);
    n_checks++;
    if (almost_full !== 1'b0 || count !== 4'd5) begin n_fail++; $display("FAIL af_at_5: af=%b count=%0d want 0 5", almost_full, count); end
    step(1'b1, 12'h206, 1'b0);
    n_checks++;
    if (almost_full !== 1'b1 || full !== 1'b0 || count !== 4'd6) begin
      n_fail++; $display("FAIL af_at_6: af=%b full=%b count=%0d want 1 0 6", almost_full, full, count);
    end
    step(1'b0, 12'h000, 1'b1);
    n_checks++;
    if (almost_full !== 1'b0 || count !== 4'd5 || data_out !== 12'h201) begin
      n_fail++; $display("FAIL af_fall: af=%b count=%0d data=%h want 0 5 201", almost_full, count, data_out);
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 12'h000;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_wrap();
    test_thresholds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
